// File: rtl/mem_arbiter.sv
// Unified single-port memory arbiter for the RV32I core.
// Arbitrates between instruction fetch and data load/store, holds one
// outstanding memory transaction, formats store lanes and extends loads,
// and stalls the PC while any access is pending.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC  = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       streak_q, streak_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                own_fetch_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          off_q;
    logic [2:0]          f3_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;

    logic                gnt_d, gnt_i;
    logic [31:0]         sel_addr;
    logic [2:0]          sel_f3;
    logic                sel_we;
    logic                sel_mis;
    logic [3:0]          sel_be;
    logic [31:0]         sel_wdata;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^{if_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

    function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    load_ext = {{24{b[7]}}, b};
            3'd1:    load_ext = {{16{h[15]}}, h};
            3'd4:    load_ext = {24'h0, b};
            3'd5:    load_ext = {16'h0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Arbitration and request formatting for the cycle's winner (IDLE only)
    always_comb begin
        gnt_d     = (state_q == IDLE) && d_req &&
                    !(if_req && (streak_q == SW'(MAX_D_STREAK)));
        gnt_i     = (state_q == IDLE) && if_req && !gnt_d;
        sel_addr  = gnt_d ? d_addr : if_addr;
        sel_f3    = gnt_d ? d_funct3 : 3'd2;
        sel_we    = gnt_d && d_we;
        sel_mis   = 1'b0;
        sel_be    = 4'b1111;
        sel_wdata = '0;
        if (gnt_i) begin
            sel_mis = (sel_addr[1:0] != 2'd0);
        end else begin
            case (sel_f3)
                3'd1, 3'd5: sel_mis = sel_addr[0];
                3'd2:       sel_mis = (sel_addr[1:0] != 2'd0);
                default:    sel_mis = 1'b0;
            endcase
        end
        if (sel_we) begin
            case (sel_f3)
                3'd0: begin
                    sel_be    = 4'b0001 << sel_addr[1:0];
                    sel_wdata = {4{d_wdata[7:0]}};
                end
                3'd1: begin
                    sel_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
                    sel_wdata = {2{d_wdata[15:0]}};
                end
                default: begin
                    sel_be    = 4'b1111;
                    sel_wdata = d_wdata;
                end
            endcase
        end
    end

    // Next-state, streak, timeout and response capture
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tcnt_d   = tcnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_d || gnt_i) begin
                    if (gnt_i)
                        streak_d = '0;
                    else if (if_req && (streak_q != SW'(MAX_D_STREAK)))
                        streak_d = streak_q + SW'(1);
                    if (sel_mis) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = WAIT;
                    tcnt_d  = '0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : load_ext(f3_q, off_q, mem_rdata);
                end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, streak, timeout counter and registered response
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tcnt_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tcnt_q   <= tcnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Latch the granted request so the memory side sees stable fields
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            own_fetch_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
        end else if (gnt_d || gnt_i) begin
            own_fetch_q <= gnt_i;
            we_q        <= sel_we;
            addr_q      <= sel_addr[ADDR_W+1:2];
            off_q       <= sel_addr[1:0];
            f3_q        <= sel_f3;
            be_q        <= sel_be;
            wdata_q     <= sel_wdata;
        end
    end

    // Outputs are forced low while reset is held, including the combinational ones
    assign if_gnt    = n_rst && gnt_i;
    assign d_gnt     = n_rst && gnt_d;
    assign if_rvalid = (state_q == RESP) && own_fetch_q;
    assign d_rvalid  = (state_q == RESP) && !own_fetch_q;
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign if_err    = if_rvalid && err_q;
    assign d_rdata   = d_rvalid ? rdata_q : '0;
    assign d_err     = d_rvalid && err_q;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_be    = mem_req ? be_q : '0;
    assign stall     = n_rst && ((state_q != IDLE) || (if_req && !gnt_i) || (d_req && !gnt_d));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions with a
// response scoreboard, plus hand sequences for timeout, starvation and reset.
module tb_mem_arbiter;

    logic        clk, n_rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall;

    mem_arbiter #(.ADDR_W(10), .MAX_D_STREAK(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .n_rst(n_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall(stall)
    );

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] mword;
        bit          mreq;
        logic [9:0]  maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          cyc;
        bit          fetch;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[19];

    int   total = 0;
    int   pass  = 0;
    int   cyc   = 0;

    // memory model controls
    bit          resp_en = 1'b0;
    bit          rv_en   = 1'b1;
    bit          pending = 1'b0;
    logic [31:0] mem_word = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ready whenever requested, read data/ack one cycle after acceptance
    always @(posedge clk) begin
        #1;
        if (resp_en) begin
            mem_rvalid = pending && rv_en;
            mem_ready  = mem_req;
            pending    = mem_req;
            mem_rdata  = mem_word;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [127:0] all_outs();
        return {9'b0, if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall};
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        bit   got   = 1'b0;
        bit   done  = 1'b0;
        bit   mseen = 1'b0;
        exp_t e;
        mem_word = v.mword;
        @(posedge clk); #1;
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_funct3 = v.f3;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (v.fetch ? if_gnt : d_gnt) begin
                got     = 1'b1;
                e.rdata = v.rdata;
                e.err   = v.err;
                e.cyc   = cyc + v.lat;
                e.fetch = v.fetch;
                sb.push_back(e);
            end else begin
                @(posedge clk);
            end
        end
        chk({nm, " gnt"}, got, 1);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            chk({nm, " stall"}, stall, 1);
            if (mem_req && !mseen) begin
                mseen = 1'b1;
                chk({nm, " mem_req"}, 1, v.mreq);
                chk({nm, " mem_addr"}, mem_addr, v.maddr);
                chk({nm, " mem_be"}, mem_be, v.be);
                chk({nm, " mem_we"}, mem_we, v.we);
                if (v.we) chk({nm, " mem_wdata"}, mem_wdata, v.mwdata);
            end
            if (if_rvalid || d_rvalid) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk({nm, " unexpected rvalid"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({nm, " owner"}, {if_rvalid, d_rvalid}, {e.fetch, !e.fetch});
                    chk({nm, " rdata"}, e.fetch ? if_rdata : d_rdata, e.rdata);
                    chk({nm, " err"}, e.fetch ? if_err : d_err, e.err);
                    chk({nm, " latency"}, cyc, e.cyc);
                end
            end
        end
        chk({nm, " rvalid seen"}, done, 1);
        if (!v.mreq) chk({nm, " no mem_req"}, mseen, 0);
        @(negedge clk);
        chk({nm, " idle stall"}, {stall, if_rvalid, d_rvalid}, 3'b000);
    endtask

    initial begin
        vec_t tv;
        int   ngnt;
        bit   done;
        bit   stale;
        logic [7:0] who;

        //        fetch we  addr          wdata         f3    mword         mreq maddr    be      mwdata        rdata         err lat
        vecs[0]  = '{1'b1, 1'b0, 32'h40,  32'h0,        3'd2, 32'h00500093, 1'b1, 10'h010, 4'hF, 32'h0,        32'h00500093, 1'b0, 3};
        vecs[1]  = '{1'b1, 1'b0, 32'h42,  32'h0,        3'd2, 32'h12345678, 1'b0, 10'h0,   4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[2]  = '{1'b0, 1'b0, 32'h10,  32'h0,        3'd2, 32'hDEADBEEF, 1'b1, 10'h004, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[3]  = '{1'b0, 1'b1, 32'h13,  32'h000000A5, 3'd0, 32'hFFFFFFFF, 1'b1, 10'h004, 4'h8, 32'hA5A5A5A5, 32'h0,        1'b0, 3};
        vecs[4]  = '{1'b0, 1'b0, 32'h13,  32'h0,        3'd0, 32'h80000000, 1'b1, 10'h004, 4'hF, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[5]  = '{1'b0, 1'b0, 32'h13,  32'h0,        3'd4, 32'h80000000, 1'b1, 10'h004, 4'hF, 32'h0,        32'h00000080, 1'b0, 3};
        vecs[6]  = '{1'b0, 1'b1, 32'h12,  32'h1234BEEF, 3'd1, 32'hFFFFFFFF, 1'b1, 10'h004, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 3};
        vecs[7]  = '{1'b0, 1'b0, 32'h12,  32'h0,        3'd1, 32'h80017FFF, 1'b1, 10'h004, 4'hF, 32'h0,        32'hFFFF8001, 1'b0, 3};
        vecs[8]  = '{1'b0, 1'b0, 32'h10,  32'h0,        3'd5, 32'h8001F00F, 1'b1, 10'h004, 4'hF, 32'h0,        32'h0000F00F, 1'b0, 3};
        vecs[9]  = '{1'b0, 1'b0, 32'h22,  32'h0,        3'd2, 32'h55555555, 1'b0, 10'h0,   4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{1'b0, 1'b0, 32'h21,  32'h0,        3'd1, 32'h55555555, 1'b0, 10'h0,   4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[11] = '{1'b0, 1'b0, 32'h21,  32'h0,        3'd0, 32'h00007F00, 1'b1, 10'h008, 4'hF, 32'h0,        32'h0000007F, 1'b0, 3};
        vecs[12] = '{1'b0, 1'b1, 32'h3FC, 32'h11223344, 3'd2, 32'hFFFFFFFF, 1'b1, 10'h0FF, 4'hF, 32'h11223344, 32'h0,        1'b0, 3};
        vecs[13] = '{1'b0, 1'b1, 32'h8,   32'hCAFEF00D, 3'd3, 32'hFFFFFFFF, 1'b1, 10'h002, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 3};
        vecs[14] = '{1'b0, 1'b0, 32'h8,   32'h0,        3'd6, 32'h89ABCDEF, 1'b1, 10'h002, 4'hF, 32'h0,        32'h89ABCDEF, 1'b0, 3};
        vecs[15] = '{1'b0, 1'b1, 32'h401, 32'h000000C3, 3'd0, 32'hFFFFFFFF, 1'b1, 10'h100, 4'h2, 32'hC3C3C3C3, 32'h0,        1'b0, 3};
        vecs[16] = '{1'b0, 1'b1, 32'h15,  32'hFFFF0000, 3'd1, 32'hFFFFFFFF, 1'b0, 10'h0,   4'h0, 32'h0,        32'h0,        1'b1, 1};
        vecs[17] = '{1'b0, 1'b0, 32'h12,  32'h0,        3'd5, 32'h8001F00F, 1'b1, 10'h004, 4'hF, 32'h0,        32'h00008001, 1'b0, 3};
        vecs[18] = '{1'b0, 1'b0, 32'h12,  32'h0,        3'd0, 32'h00C50000, 1'b1, 10'h004, 4'hF, 32'h0,        32'hFFFFFFC5, 1'b0, 3};

        n_rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_funct3 = 3'd2;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        chk("reset outputs", all_outs(), '0);
        if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        resp_en = 1'b1;

        for (int i = 0; i < 19; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // timeout: memory accepts but never answers
        rv_en = 1'b0;
        tv = '{1'b0, 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b1, 10'h004, 4'hF, 32'h0, 32'h0, 1'b1, 18};
        run_txn(tv, "timeout");
        rv_en = 1'b1;

        // starvation: both requesters held continuously
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_funct3 = 3'd2;
        ngnt = 0;
        for (int i = 0; i < 300 && ngnt < 10; i++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) chk("starve dual gnt", 1, 0);
            if (if_gnt || d_gnt) begin
                who = if_gnt ? "I" : "D";
                chk($sformatf("starve order %0d", ngnt), who, (ngnt % 5 == 4) ? "I" : "D");
                ngnt++;
            end else if (ngnt == 0) begin
                chk("starve stall", stall, 1);
            end
        end
        chk("starve grants", ngnt, 10);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
        end
        chk("starve drain", done, 1);

        // reset while waiting for memory
        rv_en = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_funct3 = 3'd2;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (d_gnt) done = 1'b1;
        end
        chk("rst txn gnt", done, 1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst in flight stall", stall, 1);
        #2;
        resp_en = 1'b0; pending = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        n_rst = 1'b0;
        #1;
        chk("rst mid-wait outputs", all_outs(), '0);
        repeat (2) @(negedge clk);
        chk("rst held outputs", all_outs(), '0);
        @(posedge clk); #3;
        n_rst = 1'b1;
        mem_word = 32'h12345678;
        mem_rdata = 32'hBAD0BAD0;
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("rst first idle gnt", {if_gnt, if_rvalid, d_rvalid}, 3'b100);
        @(posedge clk); #3;
        mem_rvalid = 1'b0;
        if_req = 1'b0;
        rv_en = 1'b1;
        resp_en = 1'b1;
        done = 1'b0; stale = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (d_rvalid) stale = 1'b1;
            if (if_rvalid) begin
                done = 1'b1;
                chk("rst fetch rdata", if_rdata, 32'h12345678);
                chk("rst fetch err", if_err, 0);
            end
        end
        chk("rst fetch done", done, 1);
        chk("rst no stale rvalid", stale, 0);
        @(negedge clk);
        chk("final idle", {stall, if_rvalid, d_rvalid, mem_req}, 4'b0000);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
